// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and FSM state definitions for the RPN calculator slice.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_CLR  = 3'b000,
    OP_MUL  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_EQ   = 3'b100,
    OP_DUP  = 3'b101,
    OP_SWAP = 3'b110,
    OP_DROP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_UNDER     = 2'b01,
    ERR_OVER      = 2'b10,
    ERR_MALFORMED = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_LOW,
    OUT
  } state_e;

endpackage

// File: rtl/rpn_stack.sv
// Register-array LIFO with push, pop, pop-two-push-one and swap; depth saturates at 0..DEPTH.
module rpn_stack #(
  parameter  int RES_W = 64,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             push,
  input  logic             pop1,
  input  logic             pop2_push1,
  input  logic             swap,
  input  logic [RES_W-1:0] wr_data,
  output logic [RES_W-1:0] top,
  output logic [RES_W-1:0] next,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty
);

  logic [RES_W-1:0] mem [DEPTH];

  assign full  = (depth == CNT_W'(DEPTH));
  assign empty = (depth == '0);

  always_comb begin
    top  = '0;
    next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i + 1) == depth) top  = mem[i];
      if (CNT_W'(i + 2) == depth) next = mem[i];
    end
  end

  // Each control is self-guarded so depth can never leave 0..DEPTH.
  always_ff @(posedge CLK) begin
    if (!RST || clr) begin
      depth <= '0;
    end else if (push && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (CNT_W'(i) == depth) mem[i] <= wr_data;
      depth <= depth + CNT_W'(1);
    end else if (pop1 && !empty) begin
      depth <= depth - CNT_W'(1);
    end else if (pop2_push1 && depth >= CNT_W'(2)) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (CNT_W'(i + 2) == depth) mem[i] <= wr_data;
      depth <= depth - CNT_W'(1);
    end else if (swap && depth >= CNT_W'(2)) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i + 1) == depth) mem[i] <= next;
        if (CNT_W'(i + 2) == depth) mem[i] <= top;
      end
    end
  end

endmodule

// File: rtl/rpn_stack_calculator.sv
// RPN evaluator: strobe/ack token input, LIFO execution with sticky errors, strobe/ack result output.
module rpn_stack_calculator
  import rpn_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int RES_W  = 64,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              input_stb,
  input  logic [DATA_W-1:0] input_data,
  input  logic              is_input_operator,
  output logic              input_ack,
  output logic              output_stb,
  output logic [RES_W-1:0]  output_data,
  output logic [1:0]        output_err,
  input  logic              output_ack,
  output logic [CNT_W-1:0]  stack_depth
);

  state_e            state;
  err_e              err, new_err;
  logic              tok_op;
  logic [DATA_W-1:0] tok_data;
  op_e               op;

  logic              st_clr, st_push, st_pop1, st_pop2, st_swap, is_eq;
  logic [RES_W-1:0]  wr_data, alu_res, top_v, next_v;
  logic [CNT_W-1:0]  depth;
  logic              full, empty;

  assign op          = op_e'(tok_data[2:0]);
  assign stack_depth = depth;

  rpn_stack #(
    .RES_W (RES_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (st_clr),
    .push       (st_push),
    .pop1       (st_pop1),
    .pop2_push1 (st_pop2),
    .swap       (st_swap),
    .wr_data    (wr_data),
    .top        (top_v),
    .next       (next_v),
    .depth      (depth),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    case (op)
      OP_MUL:  alu_res = next_v * top_v;
      OP_ADD:  alu_res = next_v + top_v;
      default: alu_res = next_v - top_v;
    endcase
  end

  // Token decode: once an error is latched, everything except CLR and EQ is a no-op.
  always_comb begin
    st_clr  = 1'b0;
    st_push = 1'b0;
    st_pop1 = 1'b0;
    st_pop2 = 1'b0;
    st_swap = 1'b0;
    is_eq   = 1'b0;
    wr_data = '0;
    new_err = err;
    if (state == OUT && output_ack) st_clr = 1'b1;
    if (state == EXEC) begin
      if (!tok_op) begin
        if (err == ERR_NONE) begin
          if (full) new_err = ERR_OVER;
          else begin
            st_push = 1'b1;
            wr_data = RES_W'(tok_data);
          end
        end
      end else if (op == OP_CLR) begin
        st_clr  = 1'b1;
        new_err = ERR_NONE;
      end else if (op == OP_EQ) begin
        is_eq = 1'b1;
        if (err == ERR_NONE) begin
          if (empty)                  new_err = ERR_UNDER;
          else if (depth > CNT_W'(1)) new_err = ERR_MALFORMED;
        end
      end else if (err == ERR_NONE) begin
        case (op)
          OP_MUL, OP_ADD, OP_SUB: begin
            if (depth < CNT_W'(2)) new_err = ERR_UNDER;
            else begin
              st_pop2 = 1'b1;
              wr_data = alu_res;
            end
          end
          OP_DUP: begin
            if (empty)     new_err = ERR_UNDER;
            else if (full) new_err = ERR_OVER;
            else begin
              st_push = 1'b1;
              wr_data = top_v;
            end
          end
          OP_SWAP: begin
            if (depth < CNT_W'(2)) new_err = ERR_UNDER;
            else                   st_swap = 1'b1;
          end
          OP_DROP: begin
            if (empty) new_err = ERR_UNDER;
            else       st_pop1 = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      err         <= ERR_NONE;
      tok_op      <= 1'b0;
      tok_data    <= '0;
      input_ack   <= 1'b0;
      output_stb  <= 1'b0;
      output_data <= '0;
      output_err  <= ERR_NONE;
    end else begin
      input_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (input_stb) begin
            tok_op    <= is_input_operator;
            tok_data  <= input_data;
            input_ack <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          err <= new_err;
          if (is_eq) begin
            output_stb  <= 1'b1;
            output_err  <= new_err;
            output_data <= (new_err == ERR_NONE) ? top_v : '0;
            state       <= OUT;
          end else begin
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!input_stb) state <= IDLE;
        end
        OUT: begin
          if (output_ack) begin
            output_stb <= 1'b0;
            err        <= ERR_NONE;
            state      <= WAIT_LOW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_calculator.sv
// Self-checking bench: queue-based RPN reference model, per-cycle output monitor, directed and random expressions.
module tb_rpn_stack_calculator;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              CLK, RST;
  logic              input_stb, is_input_operator, input_ack;
  logic [DATA_W-1:0] input_data;
  logic              output_stb, output_ack;
  logic [RES_W-1:0]  output_data;
  logic [1:0]        output_err;
  logic [CNT_W-1:0]  stack_depth;

  rpn_stack_calculator #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .input_stb         (input_stb),
    .input_data        (input_data),
    .is_input_operator (is_input_operator),
    .input_ack         (input_ack),
    .output_stb        (output_stb),
    .output_data       (output_data),
    .output_err        (output_err),
    .output_ack        (output_ack),
    .stack_depth       (stack_depth)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [63:0] stk[$];
  int          merr;
  logic [63:0] exp_data;
  logic [1:0]  exp_err;
  bit          pending;
  bit          chk_en;
  logic [63:0] last_data;
  logic [1:0]  last_err;
  int          last_depth;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: applies one token to a plain queue following the opcode rules.
  task automatic model_apply(input bit op, input logic [31:0] d);
    logic [63:0] t, u, r;
    int s;
    s = stk.size();
    if (!op) begin
      if (merr == 0) begin
        if (s == DEPTH) merr = 2;
        else stk.push_back(64'(d));
      end
    end else if (d[2:0] == 3'd0) begin
      stk.delete();
      merr = 0;
    end else if (d[2:0] == 3'd4) begin
      if (merr == 0) begin
        if (s == 0)     merr = 1;
        else if (s > 1) merr = 3;
      end
      exp_err  = 2'(merr);
      exp_data = (merr == 0) ? stk[s-1] : 64'd0;
      pending  = 1'b1;
    end else if (merr == 0) begin
      case (d[2:0])
        3'd1, 3'd2, 3'd3: begin
          if (s < 2) merr = 1;
          else begin
            t = stk.pop_back();
            u = stk.pop_back();
            if (d[2:0] == 3'd1)      r = u * t;
            else if (d[2:0] == 3'd2) r = u + t;
            else                     r = u - t;
            stk.push_back(r);
          end
        end
        3'd5: begin
          if (s == 0)          merr = 1;
          else if (s == DEPTH) merr = 2;
          else                 stk.push_back(stk[s-1]);
        end
        3'd6: begin
          if (s < 2) merr = 1;
          else begin
            t = stk[s-1];
            stk[s-1] = stk[s-2];
            stk[s-2] = t;
          end
        end
        default: begin
          if (s == 0) merr = 1;
          else        void'(stk.pop_back());
        end
      endcase
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      chk("depth", 64'(stack_depth), 64'(stk.size()));
      if (output_stb) begin
        chk("out_pending", 64'(pending), 64'd1);
        chk("out_data", output_data, exp_data);
        chk("out_err", 64'(output_err), 64'(exp_err));
      end
    end
  end

  // Presents one token, waits (bounded) for its ack and updates the model.
  task automatic fire(input bit op, input logic [31:0] d, output bit got);
    int n;
    @(negedge CLK);
    input_stb = 1'b1;
    is_input_operator = op;
    input_data = d;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge CLK);
      n++;
      if (input_ack) got = 1'b1;
    end
    chk("ack_seen", 64'(got), 64'd1);
    if (got) begin
      chk("ack_latency", 64'(n), 64'd1);
      model_apply(op, d);
    end
  endtask

  task automatic send(input bit op, input logic [31:0] d, input int hold, input int ack_delay);
    bit got;
    fire(op, d, got);
    if (!got) begin
      input_stb = 1'b0;
      repeat (4) @(negedge CLK);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("ack_once", 64'(input_ack), 64'd0);
    end
    input_stb = 1'b0;
    if (op && d[2:0] == 3'd4) begin
      @(negedge CLK);
      chk("eq_latency", 64'(output_stb), 64'd1);
      last_data  = output_data;
      last_err   = output_err;
      last_depth = int'(stack_depth);
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge CLK);
        chk("stb_hold", 64'(output_stb), 64'd1);
        chk("data_stable", output_data, last_data);
      end
      output_ack = 1'b1;
      stk.delete();
      merr = 0;
      pending = 1'b0;
      @(negedge CLK);
      output_ack = 1'b0;
      chk("stb_drop", 64'(output_stb), 64'd0);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic num(input logic [31:0] v);
    send(1'b0, v, 0, 0);
  endtask

  // Upper bits are randomised to confirm only bits [2:0] select the operation.
  task automatic opr(input logic [2:0] o);
    send(1'b1, ($urandom() & 32'hFFFF_FFF8) | 32'(o), 0, 0);
  endtask

  task automatic eq(input int ack_delay);
    send(1'b1, ($urandom() & 32'hFFFF_FFF8) | 32'd4, 0, ack_delay);
  endtask

  initial begin
    bit got;
    int len, o;
    logic [31:0] v;

    RST = 1'b0;
    input_stb = 1'b0;
    input_data = '0;
    is_input_operator = 1'b0;
    output_ack = 1'b0;
    chk_en = 1'b0;
    merr = 0;
    pending = 1'b0;
    exp_data = '0;
    exp_err = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ack", 64'(input_ack), 64'd0);
    chk("rst_stb", 64'(output_stb), 64'd0);
    chk("rst_data", output_data, 64'd0);
    chk("rst_err", 64'(output_err), 64'd0);
    chk("rst_depth", 64'(stack_depth), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk_en = 1'b1;

    // 3 4 + 5 * =
    num(3); num(4); opr(3'd2); num(5); opr(3'd1); eq(1);
    chk("pin_35", last_data, 64'd35);
    chk("pin_35_err", 64'(last_err), 64'd0);
    chk("depth_after_ack", 64'(stack_depth), 64'd0);

    // 2 7 - =
    num(2); num(7); opr(3'd3); eq(0);
    chk("pin_sub_wrap", last_data, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("pin_sub_err", 64'(last_err), 64'd0);

    // 6 DUP * 3 4 SWAP - * =  ->  36 * (4-3)
    num(6); opr(3'd5); opr(3'd1); num(3); num(4); opr(3'd6); opr(3'd3); opr(3'd1); eq(2);
    chk("pin_dup_swap", last_data, 64'd36);
    chk("pin_dup_swap_err", 64'(last_err), 64'd0);

    // + 1 =  -> underflow, then 9 =
    opr(3'd2); num(1); eq(0);
    chk("pin_under_data", last_data, 64'd0);
    chk("pin_under_err", 64'(last_err), 64'd1);
    num(9); eq(0);
    chk("pin_after_err", last_data, 64'd9);
    chk("pin_after_err_code", 64'(last_err), 64'd0);

    // DEPTH+1 pushes then =, ack held off five cycles
    for (int i = 0; i <= DEPTH; i++) num(32'(i + 100));
    eq(5);
    chk("pin_over_err", 64'(last_err), 64'd2);
    chk("pin_over_depth", 64'(last_depth), 64'(DEPTH));
    chk("pin_over_data", last_data, 64'd0);

    // 1 2 =  -> malformed
    num(1); num(2); eq(0);
    chk("pin_malformed_err", 64'(last_err), 64'd3);
    chk("pin_malformed_data", last_data, 64'd0);

    // stb held for three cycles after the ack
    send(1'b0, 32'd42, 3, 0);
    chk("hold_single_push", 64'(stack_depth), 64'd1);
    eq(0);
    chk("pin_hold", last_data, 64'd42);

    // reset while a result is pending
    num(5);
    fire(1'b1, 32'd4, got);
    input_stb = 1'b0;
    @(negedge CLK);
    chk("rst_out_stb_before", 64'(output_stb), 64'd1);
    chk_en = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_stb", 64'(output_stb), 64'd0);
    chk("rst_out_depth", 64'(stack_depth), 64'd0);
    RST = 1'b1;
    stk.delete();
    merr = 0;
    pending = 1'b0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;

    // random expressions
    for (int e = 0; e < 60; e++) begin
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) < 6) begin
          v = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 20));
          send(1'b0, v, $urandom_range(0, 2), 0);
        end else begin
          o = $urandom_range(0, 6);
          if (o >= 4) o++;
          send(1'b1, ($urandom() & 32'hFFFF_FFF8) | 32'(o), $urandom_range(0, 2), 0);
        end
      end
      eq($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
